count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//   Controls a WIDTH-bit up/down counting datapath through start/busy/done handshaking.
//   - A run starts on a start request and ends at a programmed terminal value.
//   - Runs are one-shot or auto-reloading; pause and abort are supported.
//   - Reports how many full periods have completed.
//   - Sits between a control FSM or host and the counting stage; Q feeds downstream logic.
// PARAMETERS
//   WIDTH     4   counter width in bits
//   RUN_BITS  8   width of completed-period counter (saturating)
// PORTS
//   CLK        in   1         rising-edge clock
//   reset      in   1         asynchronous, active-high reset
//   start      in   1         run request; accepted only in IDLE or DONE
//   limit      in   WIDTH     terminal/start value; sampled when start is accepted
//   reload     in   1         sampled when start is accepted; 1 = auto-reload, 0 = one-shot
//   down       in   1         sampled when start is accepted; 1 = count limit->0, 0 = count 0->limit
//   pause      in   1         level; freezes Q while in RUN/PAUSE
//   abort      in   1         forces return to IDLE
//   Q          out  WIDTH     current count
//   busy       out  1         high in RUN and PAUSE
//   done       out  1         one-cycle pulse per completed period
//   runs       out  RUN_BITS  completed periods since last accepted start; saturates at all-ones
// BEHAVIOUR
//   Reset (async, immediate)
//     - State = IDLE; Q = 0, busy = 0, done = 0, runs = 0.
//     - Latched limit, reload and down = 0.
//   Registered outputs
//     - All outputs are registered; done defaults to 0 every cycle unless set below.
//   Priority each edge
//     - reset > abort > start > pause > step/terminal.
//   IDLE
//     - start=1: latch limit/reload/down; Q <= down ? limit : 0; runs <= 0; go to RUN; busy=1 next cycle.
//   RUN
//     - abort=1: go to IDLE; Q <= 0; busy <= 0; no done pulse; runs keeps its value.
//     - pause=1: go to PAUSE; Q holds.
//     - Terminal condition: Q == latched limit (up) or Q == 0 (down).
//     - At terminal:
//       - done <= 1; runs <= runs+1, saturating.
//       - If reload: Q <= start value; stay in RUN.
//       - If one-shot: go to DONE; busy <= 0; Q holds the terminal value.
//     - Otherwise Q <= Q+1 (up) or Q-1 (down); arithmetic is modulo 2^WIDTH.
//     - Q never actually wraps, because the terminal condition is checked first.
//     - start is ignored in RUN and PAUSE.
//   PAUSE
//     - Q, runs and done = 0 hold.
//     - pause=0: go to RUN; the resume edge does not step Q.
//     - abort: as in RUN.
//   DONE
//     - Q and runs hold; busy = 0.
//     - start: behaves exactly as in IDLE; re-latches config and clears runs.
//     - abort: go to IDLE; Q <= 0.
//   Period
//     - Latched limit L gives L+1 cycles per period in both directions.
//     - L=0: done on the first RUN cycle; with reload, done every cycle.
//   Simultaneous events
//     - pause at the terminal cycle: pause wins; terminal is handled after resume.
//     - abort with start in DONE: abort wins; the FSM goes to IDLE and start is dropped.
//     - Inputs changing mid-run do not affect the run except pause and abort.
//   Reset mid-operation
//     - Returns to reset values asynchronously; no done pulse.
// TESTING
//   1. Up one-shot, limit=9
//      - Stimulus: start pulse.
//      - Required: Q=0,1,..,9; done pulses once, on the edge after Q=9.
//      - Then Q stays 9, busy=0, runs=1.
//   2. Down auto-reload, limit=3
//      - Required: Q=3,2,1,0,3,2,1,0..; done every 4th cycle; runs=3 after 12 RUN cycles.
//   3. Pause during an up run
//      - Stimulus: pause=1 for 3 cycles at Q=4.
//      - Required: Q stays 4; busy=1; resumes 4->5 one cycle after pause drops.
//   4. Abort during an up run
//      - Stimulus: abort=1 with start=1 at Q=6.
//      - Required: next cycle IDLE, Q=0, busy=0, no done pulse.
//   5. Async reset mid-run
//      - Stimulus: reset asserted between clock edges at Q=5.
//      - Required: Q=0, busy=0, runs=0 before the next CLK edge.
//   6. Boundary limits
//      - limit=15 up reload: Q runs 0..15 and back to 0, with no stray overflow.
//      - limit=0 up reload: done every cycle; runs saturates at 255 after 300 cycles.

Source files
------------

// File: rtl/count_sequencer.sv
// count_sequencer: start/busy/done sequencer for an up/down counter.
// One-shot or auto-reload runs, with pause, abort and a saturating run count.
module count_sequencer #(
   parameter int WIDTH    = 4,
   parameter int RUN_BITS = 8
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                start,
   input  logic [WIDTH-1:0]    limit,
   input  logic                reload,
   input  logic                down,
   input  logic                pause,
   input  logic                abort,
   output logic [WIDTH-1:0]    Q,
   output logic                busy,
   output logic                done,
   output logic [RUN_BITS-1:0] runs
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]    Q_ONE = 1;
   localparam logic [RUN_BITS-1:0] R_ONE = 1;

   state_t              state, state_n;
   logic [WIDTH-1:0]    lim, lim_n;
   logic                rel, rel_n;
   logic                dn, dn_n;
   logic [WIDTH-1:0]    q_n;
   logic                busy_n;
   logic                done_n;
   logic [RUN_BITS-1:0] runs_n;

   logic                term;
   logic [WIDTH-1:0]    first;
   logic [RUN_BITS-1:0] runs_inc;

   assign term     = dn ? (Q == '0) : (Q == lim);
   assign first    = dn ? lim : '0;
   assign runs_inc = (runs == '1) ? runs : runs + R_ONE;

   // State, latched run configuration and all registered outputs
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         lim   <= '0;
         rel   <= 1'b0;
         dn    <= 1'b0;
         Q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         runs  <= '0;
      end else begin
         state <= state_n;
         lim   <= lim_n;
         rel   <= rel_n;
         dn    <= dn_n;
         Q     <= q_n;
         busy  <= busy_n;
         done  <= done_n;
         runs  <= runs_n;
      end
   end

   // Next state and outputs; abort beats start beats pause beats stepping
   always_comb begin
      state_n = state;
      lim_n   = lim;
      rel_n   = rel;
      dn_n    = dn;
      q_n     = Q;
      done_n  = 1'b0;
      runs_n  = runs;
      unique case (state)
         IDLE, FIN: begin
            if (abort) begin
               state_n = IDLE;
               q_n     = '0;
            end else if (start) begin
               lim_n   = limit;
               rel_n   = reload;
               dn_n    = down;
               q_n     = down ? limit : '0;
               runs_n  = '0;
               state_n = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_n = IDLE;
               q_n     = '0;
            end else if (pause) begin
               state_n = PAUSE;
            end else if (term) begin
               done_n = 1'b1;
               runs_n = runs_inc;
               if (rel) begin
                  q_n = first;
               end else begin
                  state_n = FIN;
               end
            end else begin
               q_n = dn ? Q - Q_ONE : Q + Q_ONE;
            end
         end
         PAUSE: begin
            if (abort) begin
               state_n = IDLE;
               q_n     = '0;
            end else if (!pause) begin
               state_n = RUN;
            end
         end
         default: begin
            state_n = IDLE;
            q_n     = '0;
         end
      endcase
      busy_n = (state_n == RUN) || (state_n == PAUSE);
   end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios plus random traffic,
// checked every cycle against a period-position reference model.
module tb_count_sequencer;

   logic       CLK;
   logic       reset;
   logic       start;
   logic [3:0] limit;
   logic       reload;
   logic       down;
   logic       pause;
   logic       abort;
   logic [3:0] Q;
   logic       busy;
   logic       done;
   logic [7:0] runs;

   int tests;
   int fails;

   // model: mode 0 idle, 1 running, 2 paused, 3 finished
   int m_mode;
   int m_pos;
   int m_lim;
   bit m_rel;
   bit m_dn;
   int m_runs;
   bit m_done;
   int m_q;

   count_sequencer #(.WIDTH(4), .RUN_BITS(8)) dut (
      .CLK(CLK),
      .reset(reset),
      .start(start),
      .limit(limit),
      .reload(reload),
      .down(down),
      .pause(pause),
      .abort(abort),
      .Q(Q),
      .busy(busy),
      .done(done),
      .runs(runs)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_lim = 0;
      m_rel = 0; m_dn = 0; m_runs = 0; m_done = 0; m_q = 0;
   endtask

   // Advance the model by one clock from the current inputs
   task automatic model_step();
      m_done = 0;
      if (m_mode == 0 || m_mode == 3) begin
         if (abort) begin
            m_mode = 0; m_q = 0;
         end else if (start) begin
            m_lim = int'(limit); m_rel = reload; m_dn = down;
            m_pos = 0; m_runs = 0; m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (abort) m_mode = 0;
         else if (pause) m_mode = 2;
         else if (m_pos == m_lim) begin
            m_done = 1;
            m_runs = (m_runs + 1 > 255) ? 255 : m_runs + 1;
            if (m_rel) m_pos = 0;
            else m_mode = 3;
         end else m_pos++;
      end else begin
         if (abort) m_mode = 0;
         else if (!pause) m_mode = 1;
      end
      if (m_mode == 0) m_q = 0;
      else if (m_mode == 3) m_q = m_dn ? 0 : m_lim;
      else m_q = m_dn ? m_lim - m_pos : m_pos;
   endtask

   task automatic compare(input string tag);
      chk({tag, ".Q"}, 32'(Q), 32'(m_q));
      chk({tag, ".busy"}, 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      chk({tag, ".done"}, 32'(done), 32'(m_done));
      chk({tag, ".runs"}, 32'(runs), 32'(m_runs));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge CLK);
      #1;
      compare(tag);
   endtask

   task automatic idle_inputs();
      start = 0; pause = 0; abort = 0;
   endtask

   task automatic go(input int lim, input bit rel, input bit dn, input string tag);
      start = 1; limit = 4'(lim); reload = rel; down = dn;
      tick(tag);
      start = 0;
      limit = 4'($urandom);
      reload = 1'($urandom);
      down = 1'($urandom);
   endtask

   int dcount;

   initial begin
      tests = 0; fails = 0;
      reset = 1; start = 0; limit = 0; reload = 0;
      down = 0; pause = 0; abort = 0;
      model_reset();
      #12;
      compare("reset");
      reset = 0;

      // 1: up one-shot, limit 9
      go(9, 0, 0, "t1");
      chk("t1.q0", 32'(Q), 0);
      dcount = 0;
      for (int i = 0; i < 14; i++) begin
         tick("t1");
         if (done) dcount++;
      end
      chk("t1.pulses", dcount, 1);
      chk("t1.hold", 32'(Q), 9);
      chk("t1.runs", 32'(runs), 1);

      // 2: down auto-reload, limit 3
      go(3, 1, 1, "t2");
      chk("t2.q0", 32'(Q), 3);
      for (int i = 0; i < 12; i++) tick("t2");
      chk("t2.runs", 32'(runs), 3);
      abort = 1; tick("t2.abort"); abort = 0;

      // 3: pause at Q=4
      go(9, 0, 0, "t3");
      for (int i = 0; i < 4; i++) tick("t3");
      chk("t3.at4", 32'(Q), 4);
      pause = 1;
      for (int i = 0; i < 3; i++) tick("t3.p");
      chk("t3.frz", 32'(Q), 4);
      chk("t3.busy", 32'(busy), 1);
      pause = 0;
      tick("t3.res");
      chk("t3.res", 32'(Q), 4);
      tick("t3.step");
      chk("t3.step", 32'(Q), 5);

      // 4: abort with start at Q=6
      tick("t4");
      chk("t4.at6", 32'(Q), 6);
      abort = 1; start = 1;
      tick("t4.ab");
      idle_inputs();
      chk("t4.q", 32'(Q), 0);
      chk("t4.busy", 32'(busy), 0);
      tick("t4.idle");

      // 5: async reset between edges at Q=5
      go(9, 1, 0, "t5");
      for (int i = 0; i < 5; i++) tick("t5");
      chk("t5.at5", 32'(Q), 5);
      #2 reset = 1;
      #1;
      model_reset();
      compare("t5.rst");
      #1 reset = 0;
      tick("t5.post");

      // 6a: limit 15 up reload
      go(15, 1, 0, "t6a");
      for (int i = 0; i < 40; i++) tick("t6a");
      abort = 1; tick("t6a.ab"); abort = 0;

      // 6b: limit 0 up reload, saturation
      go(0, 1, 0, "t6b");
      for (int i = 0; i < 300; i++) tick("t6b");
      chk("t6b.sat", 32'(runs), 255);
      chk("t6b.done", 32'(done), 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         start  = ($urandom_range(0, 9) == 0);
         limit  = 4'($urandom);
         reload = 1'($urandom);
         down   = 1'($urandom);
         pause  = ($urandom_range(0, 7) == 0);
         abort  = ($urandom_range(0, 39) == 0);
         tick("rnd");
      end
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
